f_prefix_decoder: RTL and testbench

- Consumes the instruction-word stream whose prefix words carry a forced 0xF top nibble.
- Accumulates the 12-bit prefix payloads into an operand register and emits one decoded {opcode, 16-bit operand} per non-prefix word.
- Sits between instruction fetch and the ALU/control path; valid/ready handshake on both sides.

---
 rtl/f_prefix_decoder.sv | 109 ++++++++++
 tb/tb_f_prefix_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/f_prefix_decoder.sv
// f_prefix_decoder: folds 0xF-tagged prefix words into a 16-bit operand
// and emits one {opcode, operand, overflow} record per non-prefix word.
// One-deep output register with valid/ready on both sides.
//
// state | meaning
// IDLE  | no prefix pending; oreg and pcnt are zero
// ACCUM | one or more prefix words absorbed into oreg
module f_prefix_decoder #(
  parameter int       MAX_PREFIX = 2,
  parameter bit [3:0] PREFIX_NIB = 4'hF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  out_op,
  output logic [15:0] out_operand,
  output logic        out_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  // pcnt saturates at MAX_PREFIX+1, which is enough to tell "too many"
  localparam int PW = $clog2(MAX_PREFIX + 2);
  localparam logic [PW-1:0] PSAT = PW'(MAX_PREFIX + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PREFIX);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t        state, state_n;
  logic [15:0]   oreg, oreg_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic          tflag, tflag_n;
  logic          out_valid_n, out_ovf_n;
  logic [3:0]    out_op_n;
  logic [15:0]   out_operand_n;

  logic in_fire, out_fire, is_prefix, oreg_spill;

  assign in_ready   = !out_valid | out_ready;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign is_prefix  = (in_data[15:12] == PREFIX_NIB);
  // bits about to be shifted out of the 16-bit window
  assign oreg_spill = (oreg[15:4] != 12'h000);
  assign busy       = (state == ACCUM);

  // Registers: state, operand accumulator and output record
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      oreg        <= '0;
      pcnt        <= '0;
      tflag       <= 1'b0;
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_operand <= '0;
      out_ovf     <= 1'b0;
    end else begin
      state       <= state_n;
      oreg        <= oreg_n;
      pcnt        <= pcnt_n;
      tflag       <= tflag_n;
      out_valid   <= out_valid_n;
      out_op      <= out_op_n;
      out_operand <= out_operand_n;
      out_ovf     <= out_ovf_n;
    end
  end

  // Next-state: absorb prefixes, complete on a final word, drain the output
  always_comb begin
    state_n       = state;
    oreg_n        = oreg;
    pcnt_n        = pcnt;
    tflag_n       = tflag;
    out_valid_n   = out_valid;
    out_op_n      = out_op;
    out_operand_n = out_operand;
    out_ovf_n     = out_ovf;

    if (out_fire) begin
      out_valid_n = 1'b0;
    end

    if (in_fire) begin
      if (is_prefix) begin
        oreg_n  = {oreg[3:0], in_data[11:0]};
        tflag_n = tflag | oreg_spill;
        if (pcnt != PSAT) begin
          pcnt_n = pcnt + 1'b1;
        end
        state_n = ACCUM;
      end else begin
        out_valid_n   = 1'b1;
        out_op_n      = in_data[15:12];
        out_operand_n = {oreg[3:0], in_data[11:0]};
        out_ovf_n     = tflag | oreg_spill | (pcnt > PMAX);
        oreg_n        = '0;
        pcnt_n        = '0;
        tflag_n       = 1'b0;
        state_n       = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_f_prefix_decoder.sv
// Directed bench for f_prefix_decoder: each task drives a scenario and
// checks outputs against hand-computed values.
module tb_f_prefix_decoder;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_op;
  logic [15:0] out_operand;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  f_prefix_decoder #(.MAX_PREFIX(2), .PREFIX_NIB(4'hF)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_op(out_op), .out_operand(out_operand),
    .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // one rising edge, then settle before driving/sampling
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // present one word for exactly one edge (caller guarantees in_ready)
  task automatic send(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // check a completed output record
  task automatic expect_out(input string nm, input logic [3:0] op,
                            input logic [15:0] opnd, input logic ovf);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=1", nm, out_valid); end
    total++; if (out_op !== op) begin bad++; $display("FAIL %s_op got=%h exp=%h", nm, out_op, op); end
    total++; if (out_operand !== opnd) begin bad++; $display("FAIL %s_operand got=%h exp=%h", nm, out_operand, opnd); end
    total++; if (out_ovf !== ovf) begin bad++; $display("FAIL %s_ovf got=%b exp=%b", nm, out_ovf, ovf); end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
    tick(); tick();
    RST_N = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_op !== 4'h0) begin bad++; $display("FAIL reset_op got=%h exp=0", out_op); end
    total++; if (out_operand !== 16'h0) begin bad++; $display("FAIL reset_operand got=%h exp=0", out_operand); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    send(16'h3ABC);
    expect_out("single", 4'h3, 16'h0ABC, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
    drain();
  endtask

  task automatic test_prefix();
    send(16'hF005);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL prefix_busy got=%b exp=1", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prefix_novalid got=%b exp=0", out_valid); end
    send(16'h2123);
    expect_out("prefix", 4'h2, 16'h5123, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL prefix_busy_end got=%b exp=0", busy); end
    drain();
  endtask

  task automatic test_truncate();
    send(16'hF0A5);
    send(16'h2123);
    expect_out("trunc", 4'h2, 16'h5123, 1'b1);
    drain();
  endtask

  task automatic test_max_prefix();
    send(16'hF000); send(16'hF000); send(16'hF000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL maxp_busy got=%b exp=1", busy); end
    send(16'h1001);
    expect_out("maxp3", 4'h1, 16'h0001, 1'b1);
    drain();
    send(16'hF000); send(16'hF000);
    send(16'h1001);
    expect_out("maxp2", 4'h1, 16'h0001, 1'b0);
    drain();
  endtask

  task automatic test_hold_accum();
    send(16'hF007);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy cyc=%0d got=%b exp=1", i, busy); end
    end
    send(16'h6000);
    expect_out("hold", 4'h6, 16'h7000, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(16'h4111);
    in_data = 16'h5222; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      expect_out("bp_hold", 4'h4, 16'h0111, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    expect_out("bp_next", 4'h5, 16'h0222, 1'b0);
    drain();
  endtask

  task automatic test_prefix_stall();
    out_ready = 1'b0;
    send(16'h8001);
    in_data = 16'hF003; in_valid = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_busy got=%b exp=0", busy); end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drop got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_absorb got=%b exp=1", busy); end
    send(16'h1004);
    expect_out("stall", 4'h1, 16'h3004, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h1001; words[1] = 16'h2002; words[2] = 16'h3003;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      tick();
      expect_out("b2b", words[i][15:12], {4'h0, words[i][11:0]}, 1'b0);
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    send(16'hF007);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_clr got=%b exp=0", busy); end
    send(16'h1001);
    expect_out("rstmid", 4'h1, 16'h0001, 1'b0);
    drain();
  endtask

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
    #1;
    test_reset();
    test_single();
    test_prefix();
    test_truncate();
    test_max_prefix();
    test_hold_accum();
    test_backpressure();
    test_prefix_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
